// File: rtl/overlay_pkg.sv
// Shared constants for the overlay box writer: frame geometry defaults, dout field layout,
// and FSM state encodings.
package overlay_pkg;

    localparam int unsigned FRAME_W_DEF   = 800;
    localparam int unsigned FRAME_H_DEF   = 600;
    localparam int unsigned BUF1_BASE_DEF = 120000;

    localparam int unsigned LANES    = 4;
    localparam int unsigned MASK_LSB = 50;
    localparam int unsigned ADDR_LSB = 32;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StTop    = 2'd1;
    localparam logic [1:0] StBottom = 2'd2;
    localparam logic [1:0] StSides  = 2'd3;

endpackage

// File: rtl/overlay_span_mask.sv
// Byte-lane write mask for one word of a horizontal span: trims leading lanes on the
// first word and trailing lanes on the last word.
module overlay_span_mask
    import overlay_pkg::*;
(
    input  logic [1:0]       first_lane_i,
    input  logic [1:0]       last_lane_i,
    input  logic             is_first_i,
    input  logic             is_last_i,
    output logic [LANES-1:0] mask_o
);

    always_comb begin
        mask_o = 4'hF;
        if (is_first_i) mask_o = mask_o & (4'hF << first_lane_i);
        if (is_last_i)  mask_o = mask_o & (4'hF >> (2'd3 - last_lane_i));
    end

endmodule

// File: rtl/overlay_box_writer.sv
// Draws a 1-pixel rectangle outline into a packed 8bpp frame buffer as masked word writes.
// Define OVERLAY_BOX_CLIP_EN to clip the outline against FRAME_W x FRAME_H.
module overlay_box_writer
    import overlay_pkg::*;
#(
    parameter int unsigned FRAME_W   = FRAME_W_DEF,
    parameter int unsigned FRAME_H   = FRAME_H_DEF,
    parameter int unsigned BUF1_BASE = BUF1_BASE_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        box_valid,
    output logic        box_ready,
    input  logic [9:0]  box_x,
    input  logic [9:0]  box_y,
    input  logic [9:0]  box_w,
    input  logic [9:0]  box_h,
    input  logic [7:0]  box_color,
    input  logic        buffer_sel,
    output logic [53:0] dout,
    output logic        valid,
    input  logic        ready,
    output logic        busy
);

    localparam logic [10:0] FrameW       = 11'(FRAME_W);
    localparam logic [10:0] FrameH       = 11'(FRAME_H);
    localparam logic [17:0] WordsPerLine = 18'(FRAME_W / 4);
    localparam logic [17:0] Buf1Base     = 18'(BUF1_BASE);

    // Row start in words as a constant shift-add sum (800 px -> y<<7 + y<<6 + y<<3).
    function automatic logic [17:0] row_words(input logic [10:0] row);
        logic [17:0] acc;
        acc = '0;
        for (int i = 0; i < 18; i++) begin
            if (WordsPerLine[i]) acc = acc + (18'(row) << i);
        end
        return acc;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [9:0]  x_q, y_q, w_q, h_q;
    logic [7:0]  color_q;
    logic        buf_q;
    logic [8:0]  word_q, word_d;
    logic [10:0] row_q, row_d;
    logic        side_q, side_d;
    logic        valid_q, valid_d;
    logic [53:0] dout_q, dout_d;

    logic [10:0] x_end, y_end, span_end, sides_lim, beat_row, side_px;
    logic        empty, do_bottom, do_right;
    logic [8:0]  beat_word;
    logic [1:0]  lane_first, lane_last;
    logic        is_first, is_last, last_word_hit;
    logic [3:0]  beat_mask;
    logic [17:0] beat_addr;
    logic        beat_vld, can_load, load, accept;

    assign box_ready = (state_q == StIdle) & ~reset;
    assign accept    = box_valid & box_ready;
    assign can_load  = ~valid_q | ready;
    assign load      = beat_vld & can_load;

    always_comb begin
        x_end = {1'b0, x_q} + {1'b0, w_q} - 11'd1;
        y_end = {1'b0, y_q} + {1'b0, h_q} - 11'd1;
`ifdef OVERLAY_BOX_CLIP_EN
        empty     = (w_q == '0) || (h_q == '0) || ({1'b0, x_q} >= FrameW) ||
                    ({1'b0, y_q} >= FrameH);
        span_end  = (x_end >= FrameW) ? FrameW - 11'd1 : x_end;
        do_bottom = (h_q > 10'd1) && (y_end < FrameH);
        do_right  = (w_q > 10'd1) && (x_end < FrameW);
        sides_lim = (y_end < FrameH) ? y_end : FrameH;
`else
        empty     = (w_q == '0) || (h_q == '0);
        span_end  = x_end;
        do_bottom = (h_q > 10'd1);
        do_right  = (w_q > 10'd1);
        sides_lim = y_end;
`endif
    end

    always_comb begin
        side_px       = side_q ? x_end : {1'b0, x_q};
        last_word_hit = (word_q == span_end[10:2]);
        if (state_q == StSides) begin
            beat_row   = row_q;
            beat_word  = side_px[10:2];
            lane_first = side_px[1:0];
            lane_last  = side_px[1:0];
            is_first   = 1'b1;
            is_last    = 1'b1;
        end else begin
            beat_row   = (state_q == StBottom) ? y_end : {1'b0, y_q};
            beat_word  = word_q;
            lane_first = x_q[1:0];
            lane_last  = span_end[1:0];
            is_first   = (word_q == {1'b0, x_q[9:2]});
            is_last    = last_word_hit;
        end
    end

    overlay_span_mask u_span_mask (
        .first_lane_i (lane_first),
        .last_lane_i  (lane_last),
        .is_first_i   (is_first),
        .is_last_i    (is_last),
        .mask_o       (beat_mask)
    );

    assign beat_addr = (buf_q ? Buf1Base : 18'd0) + row_words(beat_row) + 18'(beat_word);

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        row_d    = row_q;
        side_d   = side_q;
        beat_vld = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StTop;
                    word_d  = {1'b0, box_x[9:2]};
                end
            end
            StTop: begin
                if (empty) begin
                    state_d = StIdle;
                end else begin
                    beat_vld = 1'b1;
                    if (can_load && last_word_hit) begin
                        state_d = StBottom;
                        word_d  = {1'b0, x_q[9:2]};
                    end else if (can_load) begin
                        word_d = word_q + 9'd1;
                    end
                end
            end
            StBottom: begin
                if (!do_bottom || (can_load && last_word_hit)) begin
                    beat_vld = do_bottom;
                    state_d  = StSides;
                    row_d    = {1'b0, y_q} + 11'd1;
                    side_d   = 1'b0;
                end else begin
                    beat_vld = 1'b1;
                    if (can_load) word_d = word_q + 9'd1;
                end
            end
            default: begin
                if (row_q >= sides_lim) begin
                    state_d = StIdle;
                end else begin
                    beat_vld = 1'b1;
                    if (can_load && !side_q && do_right) begin
                        side_d = 1'b1;
                    end else if (can_load) begin
                        side_d = 1'b0;
                        row_d  = row_q + 11'd1;
                        // Leave straight from the last side write so busy drops on its transfer.
                        if (row_q + 11'd1 >= sides_lim) state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        dout_d  = dout_q;
        if (load) begin
            valid_d                 = 1'b1;
            dout_d[MASK_LSB +: 4]   = beat_mask;
            dout_d[ADDR_LSB +: 18]  = beat_addr;
            dout_d[31:0]            = {4{color_q}};
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            buf_q   <= 1'b0;
            word_q  <= '0;
            row_q   <= '0;
            side_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            row_q   <= row_d;
            side_q  <= side_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            if (accept) begin
                x_q     <= box_x;
                y_q     <= box_y;
                w_q     <= box_w;
                h_q     <= box_h;
                color_q <= box_color;
                buf_q   <= buffer_sel;
            end
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign busy  = (state_q != StIdle) | valid_q;

endmodule

// File: tb/tb_overlay_box_writer.sv
// Directed table-driven bench for overlay_box_writer with stall, zero-size and reset sequences.
module tb_overlay_box_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        box_valid = 1'b0;
    logic        box_ready;
    logic [9:0]  box_x = '0, box_y = '0, box_w = '0, box_h = '0;
    logic [7:0]  box_color = '0;
    logic        buffer_sel = 1'b0;
    logic [53:0] dout;
    logic        valid;
    logic        ready = 1'b1;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [9:0] x, y, w, h;
        logic [7:0] color;
        logic       bsel;
        int         stall_at;
        int         stall_len;
        bit         busy_drop;
        int         first;
        int         nexp;
    } vec_t;

    typedef struct {
        logic [3:0]  mask;
        logic [17:0] addr;
    } wr_t;

    vec_t vecs[$];
    wr_t  exps[$];

    overlay_box_writer dut (
        .clock      (clock),
        .reset      (reset),
        .box_valid  (box_valid),
        .box_ready  (box_ready),
        .box_x      (box_x),
        .box_y      (box_y),
        .box_w      (box_w),
        .box_h      (box_h),
        .box_color  (box_color),
        .buffer_sel (buffer_sel),
        .dout       (dout),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    function automatic void add_vec(input int x, input int y, input int w, input int h,
                                    input int color, input int bsel, input int stall_at,
                                    input int stall_len, input bit busy_drop);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y); v.w = 10'(w); v.h = 10'(h);
        v.color = 8'(color); v.bsel = 1'(bsel);
        v.stall_at = stall_at; v.stall_len = stall_len; v.busy_drop = busy_drop;
        v.first = exps.size(); v.nexp = 0;
        vecs.push_back(v);
    endfunction

    function automatic void add_wr(input int mask, input int addr);
        wr_t w;
        w.mask = 4'(mask); w.addr = 18'(addr);
        exps.push_back(w);
        vecs[vecs.size()-1].nexp++;
    endfunction

    task automatic issue(input vec_t v);
        int cyc = 0;
        while (!box_ready && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("box_ready_before_cmd", 64'(box_ready), 64'(1));
        box_x = v.x; box_y = v.y; box_w = v.w; box_h = v.h;
        box_color = v.color; buffer_sel = v.bsel; box_valid = 1'b1;
        @(posedge clock); #1;
        // Scramble inputs after acceptance; the DUT must use its latched copy.
        box_valid = 1'b0;
        box_x = 10'($urandom); box_y = 10'($urandom); box_w = 10'($urandom);
        box_h = 10'($urandom); box_color = 8'($urandom); buffer_sel = ~v.bsel;
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        wr_t got[$];
        logic [31:0] dat[$];
        logic [53:0] snap = '0;
        int cyc = 0, stall = 0;
        bit done = 0, hold = 0, drop_checked = 0;
        v = vecs[vi];
        issue(v);
        if (v.nexp > 0) check($sformatf("v%0d_busy_after_accept", vi), 64'(busy), 64'(1));
        while (!done && cyc < 400) begin
            ready = !(v.stall_len > 0 && got.size() == v.stall_at && stall < v.stall_len);
            if (!ready) stall++;
            @(negedge clock);
            if (hold) check($sformatf("v%0d_hold", vi), {9'd0, valid, dout}, {9'd0, 1'b1, snap});
            hold = valid && !ready;
            snap = dout;
            if (valid && ready) begin
                wr_t w;
                w.mask = dout[53:50];
                w.addr = dout[49:32];
                got.push_back(w);
                dat.push_back(dout[31:0]);
            end
            @(posedge clock); #1;
            cyc++;
            if (v.busy_drop && !drop_checked && got.size() == v.nexp) begin
                check($sformatf("v%0d_busy_drop", vi), 64'(busy), 64'(0));
                drop_checked = 1;
            end
            done = !busy;
        end
        ready = 1'b1;
        check($sformatf("v%0d_done", vi), 64'(done), 64'(1));
        check($sformatf("v%0d_count", vi), 64'(got.size()), 64'(v.nexp));
        if (v.nexp == 0)
            check($sformatf("v%0d_idle_within_2", vi), 64'(cyc <= 2 && box_ready), 64'(1));
        for (int i = 0; i < v.nexp && i < got.size(); i++) begin
            check($sformatf("v%0d_wr%0d_mask_addr", vi, i),
                  {42'd0, got[i].mask, got[i].addr},
                  {42'd0, exps[v.first+i].mask, exps[v.first+i].addr});
            check($sformatf("v%0d_wr%0d_data", vi, i), 64'(dat[i]), 64'({4{v.color}}));
        end
    endtask

    initial begin
        int n;
        // x, y, w, h, color, buf, stall_at, stall_len, busy_drop
        add_vec(0, 0, 8, 2, 'hFF, 0, 0, 0, 0);
        add_wr('hF, 0); add_wr('hF, 1); add_wr('hF, 200); add_wr('hF, 201);
        add_vec(2, 10, 5, 3, 'h3C, 0, 0, 0, 1);
        add_wr('hC, 2000); add_wr('h7, 2001); add_wr('hC, 2400); add_wr('h7, 2401);
        add_wr('h4, 2200); add_wr('h4, 2201);
        add_vec(0, 0, 8, 2, 'hFF, 1, 0, 0, 0);
        add_wr('hF, 120000); add_wr('hF, 120001); add_wr('hF, 120200); add_wr('hF, 120201);
        add_vec(2, 10, 5, 3, 'h3C, 0, 1, 5, 1);
        add_wr('hC, 2000); add_wr('h7, 2001); add_wr('hC, 2400); add_wr('h7, 2401);
        add_wr('h4, 2200); add_wr('h4, 2201);
        add_vec(7, 7, 0, 4, 'h12, 0, 0, 0, 0);
        add_vec(1, 1, 5, 0, 'h34, 0, 0, 0, 0);
        add_vec(5, 1, 1, 1, 'h11, 0, 0, 0, 0);
        add_wr('h2, 201);
        add_vec(3, 0, 2, 4, 'h80, 0, 0, 0, 1);
        add_wr('h8, 0); add_wr('h1, 1); add_wr('h8, 600); add_wr('h1, 601);
        add_wr('h8, 200); add_wr('h1, 201); add_wr('h8, 400); add_wr('h1, 401);
        add_vec(4, 2, 1, 3, 'h5A, 0, 0, 0, 1);
        add_wr('h1, 401); add_wr('h1, 801); add_wr('h1, 601);
        add_vec(1, 5, 14, 2, 'h0F, 0, 0, 0, 0);
        add_wr('hE, 1000); add_wr('hF, 1001); add_wr('hF, 1002); add_wr('h7, 1003);
        add_wr('hE, 1200); add_wr('hF, 1201); add_wr('hF, 1202); add_wr('h7, 1203);
`ifdef OVERLAY_BOX_CLIP_EN
        add_vec(798, 599, 10, 5, 'h77, 0, 0, 0, 0);
        add_wr('hC, 119999);
`endif

        // Reset cycle: everything quiet, box_ready low while reset is held.
        @(posedge clock); #1;
        check("rst_box_ready", 64'(box_ready), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_dout", 64'(dout), 64'(0));
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_rst_box_ready", 64'(box_ready), 64'(1));

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Reset while drawing the side rows abandons the box.
        issue(vecs[1]);
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clock);
            if (valid && ready) n++;
            @(posedge clock); #1;
        end
        check("midreset_reached_sides", 64'(n), 64'(4));
        check("midreset_pending_write", 64'(valid), 64'(1));
        reset = 1'b1;
        @(posedge clock); #1;
        check("midreset_valid", 64'(valid), 64'(0));
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_box_ready", 64'(box_ready), 64'(0));
        reset = 1'b0;
        @(posedge clock); #1;
        check("midreset_ready_after", 64'(box_ready), 64'(1));
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/overlay_box_writer.md
OVERLAY_BOX_WRITER -- requirements
Module: overlay_box_writer

Interface
REQ-001 SHALL have parameter FRAME_W, default 800, meaning visible pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 600, meaning visible lines per frame.
REQ-003 SHALL have parameter BUF1_BASE, default 120000, meaning word address of frame buffer 1; buffer 0 is at word 0.
REQ-004 SHALL have these ports: clock in 1, sole clock; reset in 1, synchronous active-high.
REQ-005 SHALL have box_valid in 1 and box_ready out 1, forming the command handshake.
REQ-006 SHALL have box_x, box_y, box_w, box_h in 10 each, giving the box origin and size in pixels.
REQ-007 SHALL have box_color in 8, giving the outline intensity.
REQ-008 SHALL have buffer_sel in 1, selecting the target frame buffer.
REQ-009 SHALL have dout out 54, carrying {mask[3:0], addr[17:0], data[31:0]} for the SRAM arbiter W1 port, plus valid out 1 and ready in 1.
REQ-010 SHALL have busy out 1, high while a box is being drawn.

Function
REQ-011 SHALL accept a command on box_valid&box_ready, and SHALL assert box_ready only in IDLE.
REQ-012 SHALL latch all command fields and buffer_sel at acceptance, so later input changes have no effect.
REQ-013 SHALL pack 4 pixels per word: pixel (x,y) maps to word base+(y*FRAME_W+x)>>2, lane x[1:0], byte data[8*lane+7:8*lane], mask bit lane (1 = write).
REQ-014 SHALL drive data as box_color replicated in all four bytes.
REQ-015 SHALL compute row base with shift-add (y*200 = y<<7 + y<<6 + y<<3) and SHALL use no multiplier.
REQ-016 SHALL use FSM states IDLE, TOP, BOTTOM, SIDES and IDLE, in that order; each skipped state advances in 1 cycle.
REQ-017 TOP SHALL write row y, pixels x..x+w-1, one word per beat, with the mask covering only in-range lanes.
REQ-018 BOTTOM SHALL do the same for row y+h-1 and SHALL be skipped when h<2.
REQ-019 SIDES SHALL write, for rows y+1..y+h-2 in ascending order, the left pixel x and then the right pixel x+w-1; the right write SHALL be omitted when w<2.
REQ-020 Zero size (w==0 or h==0) SHALL produce no writes; the FSM SHALL return to IDLE within 2 cycles.
REQ-021 SHALL use standard valid/ready on the output: dout stays stable while valid&~ready, and valid never drops without a transfer.
REQ-022 SHALL sustain 1 write per cycle while ready is held high.
REQ-023 SHALL keep busy high from the cycle after acceptance until the last write transfers.

Reset
REQ-024 On reset SHALL go to IDLE with valid=0, busy=0, box_ready=0 in the reset cycle and 1 afterwards, and dout=0.
REQ-025 Reset during drawing SHALL abandon the box immediately; a pending unaccepted write SHALL be dropped.

Configuration
REQ-026 With OVERLAY_BOX_CLIP_EN defined:
- pixels with x>=FRAME_W or y>=FRAME_H SHALL be suppressed;
- a right edge or bottom edge lying off-frame SHALL be skipped;
- an origin off-frame SHALL produce no writes.
REQ-027 Without OVERLAY_BOX_CLIP_EN, the caller guarantees x+w<=FRAME_W and y+h<=FRAME_H; out-of-range commands produce unspecified writes, but the FSM SHALL still terminate.

Structure
REQ-028 Shared package overlay_pkg SHALL hold the state enum, the dout field offsets (MASK_LSB=50, ADDR_LSB=32), and FRAME_W/FRAME_H/BUF1_BASE defaults.
REQ-029 Sub-module overlay_span_mask SHALL map (first lane, last lane, word is first/last) to a 4-bit mask combinationally.

Verification
REQ-030 x=0,y=0,w=8,h=2,color=FF,buf0, ready=1 -> 4 writes {F,0},{F,1},{F,200},{F,201}, data FFFFFFFF, no SIDES writes.
REQ-031 x=2,y=10,w=5,h=3,color=3C, ready=1 -> writes in this order:
- (mask,addr) {C,2000},{7,2001}, then {C,2400},{7,2401}, then {4,2200},{4,2201};
- data 3C3C3C3C;
- busy drops the cycle after the 6th transfer.
REQ-032 The REQ-030 box with buf_sel=1 -> the same masks, addrs +120000.
REQ-033 REQ-031 with ready deasserted for 5 cycles at the 2nd beat -> dout/valid held constant, same 6-write sequence, no duplicates.
REQ-034 CLIP_EN: x=798,y=599,w=10,h=5 -> exactly 1 write, mask C, addr 119999.
REQ-035 w=0 -> no valid; box_ready high again within 2 cycles. Reset asserted mid-SIDES -> valid=0 the next cycle, IDLE, and the following command executes correctly.
